// File: rtl/alu_writeback_pkg.sv
// Shared opcode map, flag bit positions and FSM encoding for the ALU writeback stage.
package alu_writeback_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_MUL  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_XOR  = 8'h06;
    localparam logic [7:0] OP_NOT  = 8'h07;
    localparam logic [7:0] OP_SHL  = 8'h08;
    localparam logic [7:0] OP_SHR  = 8'h09;
    localparam logic [7:0] OP_SRA  = 8'h0A;
    localparam logic [7:0] OP_ROL  = 8'h0B;
    localparam logic [7:0] OP_ROR  = 8'h0C;
    localparam logic [7:0] OP_SLT  = 8'h0D;
    localparam logic [7:0] OP_SLTU = 8'h0E;
    localparam logic [7:0] OP_MIN  = 8'h0F;
    localparam logic [7:0] OP_MAX  = 8'h10;
    localparam logic [7:0] OP_XNOR = 8'h11;
    localparam logic [7:0] OP_LAST = 8'h11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR0  = 2'd1,
        ST_WR1  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/alu_writeback_op_class.sv
// Opcode class decoder: NOP, MUL (two write beats) and illegal (above OP_LAST).
module alu_op_class
    import alu_writeback_pkg::*;
(
    input  logic [7:0] op,
    output logic       is_nop,
    output logic       is_mul,
    output logic       is_illegal
);

    assign is_nop     = (op == OP_NOP);
    assign is_mul     = (op == OP_MUL);
    assign is_illegal = (op > OP_LAST);

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: drives one register-file write port and owns the flags register.
// Build option ALU_WB_ZERO_REG_EN: register index 0 is hardwired zero and its beats are skipped.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] q0,
    input  logic [DATA_W-1:0] q1,
    input  logic [3:0]        st,
    input  logic [REG_AW-1:0] rd0,
    input  logic [REG_AW-1:0] rd1,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_wready,
    output logic [3:0]        flags,
    output logic              retire,
    output logic              bad_op
);

`ifdef ALU_WB_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    // A beat requests a write unless it targets the hardwired-zero register.
    function automatic logic beat_we(input logic [REG_AW-1:0] addr);
        return !(ZERO_REG && (addr == '0));
    endfunction

    wb_state_t         state, state_nxt;
    logic              is_nop, is_mul, is_illegal;
    logic              accept, beat_done;
    logic              mul_p0;
    logic [DATA_W-1:0] q1_p0;
    logic [REG_AW-1:0] rd1_p0;
    logic [3:0]        st_p0;
    logic              rf_we_nxt, retire_nxt, bad_op_nxt;
    logic [REG_AW-1:0] rf_waddr_nxt;
    logic [DATA_W-1:0] rf_wdata_nxt;
    logic [3:0]        flags_nxt;

    alu_op_class u_op_class (
        .op         (op),
        .is_nop     (is_nop),
        .is_mul     (is_mul),
        .is_illegal (is_illegal)
    );

    assign accept    = (state == ST_IDLE) && in_valid;
    // A skipped beat (no rf_we) completes without waiting on the register file.
    assign beat_done = rf_wready || (ZERO_REG && !rf_we);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && !is_nop && !is_illegal) state_nxt = ST_WR0;
            ST_WR0:  if (beat_done) state_nxt = mul_p0 ? ST_WR1 : ST_IDLE;
            ST_WR1:  if (beat_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state == ST_IDLE);
        rf_we_nxt    = rf_we;
        rf_waddr_nxt = rf_waddr;
        rf_wdata_nxt = rf_wdata;
        flags_nxt    = flags;
        retire_nxt   = 1'b0;
        bad_op_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_illegal) begin
                        bad_op_nxt = 1'b1;
                    end else if (is_nop) begin
                        retire_nxt = 1'b1;
                    end else begin
                        rf_we_nxt    = beat_we(rd0);
                        rf_waddr_nxt = rd0;
                        rf_wdata_nxt = q0;
                    end
                end
            end
            ST_WR0: begin
                if (beat_done) begin
                    if (mul_p0) begin
                        rf_we_nxt    = beat_we(rd1_p0);
                        rf_waddr_nxt = rd1_p0;
                        rf_wdata_nxt = q1_p0;
                    end else begin
                        rf_we_nxt  = 1'b0;
                        retire_nxt = 1'b1;
                        flags_nxt  = st_p0;
                    end
                end
            end
            ST_WR1: begin
                if (beat_done) begin
                    rf_we_nxt  = 1'b0;
                    retire_nxt = 1'b1;
                    flags_nxt  = st_p0;
                end
            end
            default: rf_we_nxt = 1'b0;
        endcase
    end

    // Bundle capture: held for the whole write sequence, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            mul_p0 <= is_mul;
            q1_p0  <= q1;
            rd1_p0 <= rd1;
            st_p0  <= st;
        end
    end

    // Registered write port, flags and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            flags    <= 4'b0000;
            retire   <= 1'b0;
            bad_op   <= 1'b0;
        end else begin
            rf_we    <= rf_we_nxt;
            rf_waddr <= rf_waddr_nxt;
            rf_wdata <= rf_wdata_nxt;
            flags    <= flags_nxt;
            retire   <= retire_nxt;
            bad_op   <= bad_op_nxt;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback; honours ALU_WB_ZERO_REG_EN when defined.
module tb_alu_writeback;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        op = '0;
    logic [DATA_W-1:0] q0 = '0;
    logic [DATA_W-1:0] q1 = '0;
    logic [3:0]        st = '0;
    logic [REG_AW-1:0] rd0 = '0;
    logic [REG_AW-1:0] rd1 = '0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_wready = 1'b1;
    logic [3:0]        flags;
    logic              retire;
    logic              bad_op;

    alu_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .q0(q0), .q1(q1), .st(st), .rd0(rd0), .rd1(rd1),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wready(rf_wready), .flags(flags), .retire(retire), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef struct packed {
        logic       is_bad;
        logic [3:0] fl;
    } evt_t;

    beat_t beat_q[$];
    evt_t  evt_q[$];
    logic [3:0] exp_flags = 4'b0000;
    int n_chk  = 0;
    int n_pass = 0;
    bit rand_rdy = 1'b0;
    bit mon_en   = 1'b0;

`ifdef ALU_WB_ZERO_REG_EN
    localparam bit ZREG = 1'b1;
`else
    localparam bit ZREG = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        else
            n_pass++;
    endtask

    // Reference model: what each bundle must produce, in order.
    task automatic push_expect(input logic [7:0] o, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic [3:0] s, input logic [REG_AW-1:0] r0, input logic [REG_AW-1:0] r1);
        if (o == 8'h00) begin
            evt_q.push_back('{is_bad: 1'b0, fl: exp_flags});
        end else if (o > 8'h11) begin
            evt_q.push_back('{is_bad: 1'b1, fl: exp_flags});
        end else begin
            if (!(ZREG && r0 == '0)) beat_q.push_back('{addr: r0, data: a});
            if (o == 8'h04 && !(ZREG && r1 == '0)) beat_q.push_back('{addr: r1, data: b});
            exp_flags = s;
            evt_q.push_back('{is_bad: 1'b0, fl: s});
        end
    endtask

    // Drive a bundle right after a rising edge and hold it until accepted.
    task automatic send(input logic [7:0] o, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [3:0] s, input logic [REG_AW-1:0] r0, input logic [REG_AW-1:0] r1);
        bit acc;
        int waited;
        push_expect(o, a, b, s, r0, r1);
        op = o; q0 = a; q1 = b; st = s; rd0 = r0; rd1 = r1;
        in_valid = 1'b1;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 50) begin
            acc = in_ready;
            @(posedge clk); #1;
            waited++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        op = $urandom; q0 = $urandom; q1 = $urandom; st = $urandom; rd0 = $urandom; rd1 = $urandom;
    endtask

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rf_wready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: every completed write and every pulse is matched against the queues.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (rf_we && rf_wready) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", {rf_waddr, rf_wdata}, 64'd0);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_addr", rf_waddr, b.addr);
                    chk("beat_data", rf_wdata, b.data);
                end
            end
            chk("retire_badop_excl", retire & bad_op, 1'b0);
            if (retire || bad_op) begin
                if (evt_q.size() == 0) begin
                    chk("unexpected_pulse", {retire, bad_op}, 2'b00);
                end else begin
                    evt_t e;
                    e = evt_q.pop_front();
                    chk("pulse_kind", bad_op, e.is_bad);
                    chk("pulse_flags", flags, e.fl);
                end
            end
        end
    end

    initial begin
        logic [7:0] op_tab [12];
        op_tab = '{8'h01, 8'h02, 8'h04, 8'h04, 8'h11, 8'h12, 8'h00, 8'h05, 8'h10, 8'hFF, 8'h06, 8'h03};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, '0);
        chk("rst_wdata", rf_wdata, '0);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_retire", retire, 1'b0);
        chk("rst_bad_op", bad_op, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // ADD: one beat, in_ready back after two cycles
        rf_wready = 1'b1;
        send(8'h01, 32'h0000_0005, 32'h0, 4'b0000, 5'd3, 5'd0);
        @(negedge clk);
        chk("add_we_latency", rf_we, 1'b1);
        chk("add_busy", in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("add_ready_back", in_ready, 1'b1);
        chk("add_flags", flags, 4'b0000);

        // MUL: two beats, one retire
        send(8'h04, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0010, 5'd4, 5'd5);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("mul_flags", flags, 4'b0010);

        // SUB with three stalled cycles
        rf_wready = 1'b0;
        send(8'h02, 32'hDEAD_BEEF, 32'h0, 4'b0100, 5'd7, 5'd0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_we", rf_we, 1'b1);
            chk("stall_addr", rf_waddr, 5'd7);
            chk("stall_data", rf_wdata, 32'hDEAD_BEEF);
            chk("stall_flags_old", flags, 4'b0010);
            @(posedge clk); #1;
        end
        rf_wready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_flags_new", flags, 4'b0100);
        chk("stall_we_drop", rf_we, 1'b0);

        // NOP then illegal; boundary ops 0x11 / 0x12
        send(8'h00, 32'h1, 32'h2, 4'b1111, 5'd9, 5'd9);
        send(8'h20, 32'h1, 32'h2, 4'b1111, 5'd9, 5'd9);
        @(negedge clk);
        chk("nop_bad_flags", flags, 4'b0100);
        send(8'h11, 32'h1111_0000, 32'h0, 4'b1001, 5'd17, 5'd0);
        repeat (2) begin @(posedge clk); #1; end
        send(8'h12, 32'h1, 32'h2, 4'b0110, 5'd1, 5'd1);
        @(negedge clk);
        chk("illegal_flags", flags, 4'b1001);

        // MUL with rd0 == rd1
        send(8'h04, 32'hAAAA_0001, 32'h5555_0002, 4'b1000, 5'd12, 5'd12);
        repeat (3) begin @(posedge clk); #1; end

        // Index 0 destination
        rf_wready = 1'b0;
        send(8'h06, 32'h0000_00F0, 32'h0, 4'b0101, 5'd0, 5'd0);
        @(negedge clk);
        chk("zero_we", rf_we, ZREG ? 1'b0 : 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_retire", retire, ZREG ? 1'b1 : 1'b0);
        rf_wready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Reset during WR1 of a MUL
        rf_wready = 1'b0;
        send(8'h04, 32'h0000_0077, 32'h0000_0088, 4'b0001, 5'd20, 5'd21);
        rf_wready = 1'b1;
        @(posedge clk); #1;
        rf_wready = 1'b0;
        @(negedge clk);
        chk("rst_mul_in_wr1", {rf_we, rf_waddr}, {1'b1, 5'd21});
        @(posedge clk); #1;
        beat_q.delete();
        evt_q.delete();
        exp_flags = 4'b0000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_abort_we", rf_we, 1'b0);
        chk("rst_abort_flags", flags, 4'b0000);
        chk("rst_abort_retire", retire, 1'b0);
        chk("rst_abort_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Random traffic with random write backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] o;
            o = (i % 3 == 2) ? 8'($urandom_range(0, 255)) : op_tab[i % 12];
            send(o, $urandom, $urandom, 4'($urandom), 5'($urandom), 5'($urandom));
        end
        for (int w = 0; w < 200 && (beat_q.size() != 0 || evt_q.size() != 0); w++) begin
            @(posedge clk); #1;
        end
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        chk("drain_beats", beat_q.size(), 0);
        chk("drain_events", evt_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
